// File: rtl/cordic_fixedpoint_phase_prep_if.sv
// Handshake bundle for the CORDIC phase-prep stage.
// slave: DUT view (sample in, folded phase out); master: driver view.
interface cordic_fixedpoint_phase_prep_if;
  logic        iValid;
  logic        oReady;
  logic [22:0] iPhase;
  logic        oValid;
  logic        iReady;
  logic [20:0] oPhase_abs;
  logic        oSign;
  logic        oFold;
  logic        oRange_err;

  modport slave (
    input  iValid, iPhase, iReady,
    output oReady, oValid, oPhase_abs,
    output oSign, oFold, oRange_err
  );

  modport master (
    output iValid, iPhase, iReady,
    input  oReady, oValid, oPhase_abs,
    input  oSign, oFold, oRange_err
  );
endinterface

// File: rtl/cordic_fixedpoint_phase_prep.sv
// CORDIC phase prep: saturate Q2.20 phase to [-pi,pi], fold to [-pi/2,pi/2].
// Ports: iClk, iReset (sync, high), bus (slave): valid/ready in and out.
module cordic_fixedpoint_phase_prep (
  input logic iClk,
  input logic iReset,
  cordic_fixedpoint_phase_prep_if.slave bus
);
  localparam logic signed [23:0] PI = 24'sd3294199;
  localparam logic signed [23:0] HALF_PI = 24'sd1647099;

  logic        s1_valid_q;
  logic [22:0] s1_phase_q;
  logic        s1_err_q;
  logic        out_valid_q;
  logic [20:0] abs_q;
  logic        sign_q;
  logic        fold_q;
  logic        err_q;

  logic        s2_adv;
  logic        s1_adv;

  logic signed [23:0] in_ext;
  logic [22:0] sat_d;
  logic        sat_err_d;

  logic signed [23:0] s1_ext;
  logic signed [23:0] q;
  logic signed [23:0] neg_q;
  logic        fold_d;
  logic        sign_d;
  logic [20:0] abs_d;
  logic        unused_bits;

  assign s2_adv = !out_valid_q || bus.iReady;
  assign s1_adv = !s1_valid_q || s2_adv;
  assign bus.oReady = s1_adv;

  assign in_ext = {bus.iPhase[22], bus.iPhase};
  assign s1_ext = {s1_phase_q[22], s1_phase_q};

  always_comb begin
    sat_d = bus.iPhase;
    sat_err_d = 1'b0;
    if (in_ext > PI) begin
      sat_d = PI[22:0];
      sat_err_d = 1'b1;
    end else if (in_ext < -PI) begin
      sat_d = 23'(-PI);
      sat_err_d = 1'b1;
    end
  end

  // |q| <= pi/2 after folding, so 21 bits hold the magnitude exactly
  always_comb begin
    q = s1_ext;
    fold_d = 1'b0;
    if (s1_ext > HALF_PI) begin
      q = s1_ext - PI;
      fold_d = 1'b1;
    end else if (s1_ext < -HALF_PI) begin
      q = s1_ext + PI;
      fold_d = 1'b1;
    end
    neg_q = -q;
    sign_d = q[23];
    abs_d = sign_d ? neg_q[20:0] : q[20:0];
  end

  assign unused_bits = ^{q[22:21], neg_q[23:21]};

  always_ff @(posedge iClk) begin
    if (iReset) begin
      s1_valid_q <= 1'b0;
      s1_phase_q <= '0;
      s1_err_q <= 1'b0;
      out_valid_q <= 1'b0;
      abs_q <= '0;
      sign_q <= 1'b0;
      fold_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= bus.iValid;
        if (bus.iValid) begin
          s1_phase_q <= sat_d;
          s1_err_q <= sat_err_d;
        end
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          abs_q <= abs_d;
          sign_q <= sign_d;
          fold_q <= fold_d;
          err_q <= s1_err_q;
        end
      end
    end
  end

  assign bus.oValid = out_valid_q;
  assign bus.oPhase_abs = abs_q;
  assign bus.oSign = sign_q;
  assign bus.oFold = fold_q;
  assign bus.oRange_err = err_q;
endmodule

// File: tb/tb_cordic_fixedpoint_phase_prep.sv
// Scoreboard bench for cordic_fixedpoint_phase_prep.
// Directed vectors, stall stream, mid-stream reset, random traffic.
module tb_cordic_fixedpoint_phase_prep;
  typedef struct packed {
    logic [20:0] abs;
    logic sign;
    logic fold;
    logic err;
  } exp_t;

  localparam int PI = 3294199;
  localparam int HP = 1647099;

  logic iClk = 1'b0;
  logic iReset;
  always #5 iClk = ~iClk;

  cordic_fixedpoint_phase_prep_if bus ();

  cordic_fixedpoint_phase_prep dut (
    .iClk(iClk),
    .iReset(iReset),
    .bus(bus)
  );

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int bp_mode = 0;
  int stall_cyc = 0;
  bit saw_not_ready = 0;
  bit stall_prev = 0;
  logic [24:0] snap;

  task automatic check(string nm, logic [63:0] act, logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  function automatic exp_t model(logic [22:0] ph);
    int p;
    int q;
    exp_t e;
    p = int'($signed(ph));
    e.err = 1'b0;
    if (p > PI) begin
      p = PI;
      e.err = 1'b1;
    end else if (p < -PI) begin
      p = -PI;
      e.err = 1'b1;
    end
    e.fold = 1'b1;
    if (p > HP) q = p - PI;
    else if (p < -HP) q = p + PI;
    else begin
      q = p;
      e.fold = 1'b0;
    end
    e.sign = (q < 0);
    e.abs = 21'((q < 0) ? -q : q);
    return e;
  endfunction

  function automatic exp_t mk(int a, bit s, bit f, bit r);
    exp_t e;
    e.abs = 21'(a);
    e.sign = s;
    e.fold = f;
    e.err = r;
    return e;
  endfunction

  // Backpressure source, updated just after each rising edge
  always @(posedge iClk) begin
    #1;
    if (bp_mode == 0) bus.iReady = 1'b1;
    else if (bp_mode == 1) bus.iReady = ($urandom_range(0, 3) != 0);
    else begin
      stall_cyc++;
      bus.iReady = !(stall_cyc >= 3 && stall_cyc <= 6);
    end
  end

  // Monitor: transfers are decided at the next rising edge
  always @(negedge iClk) begin
    exp_t e;
    logic [24:0] cur;
    cur = {bus.oValid, bus.oPhase_abs, bus.oSign, bus.oFold, bus.oRange_err};
    if (iReset) begin
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      if (!bus.oReady) saw_not_ready = 1'b1;
      if (stall_prev) check("stall_stable", 64'(cur), 64'(snap));
      stall_prev = bus.oValid && !bus.iReady;
      snap = cur;
      if (bus.oValid && bus.iReady) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'(cur), 64'(0));
        end else begin
          e = sb.pop_front();
          check("result", 64'(cur[23:0]), 64'(e));
        end
      end
    end
  end

  task automatic send(input logic [22:0] ph, input exp_t e);
    bit acc;
    int n;
    n = 0;
    bus.iValid = 1'b1;
    bus.iPhase = ph;
    do begin
      @(negedge iClk);
      acc = bus.oReady;
      if (acc) sb.push_back(e);
      @(posedge iClk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("accept_timeout", 64'(0), 64'(1));
    bus.iValid = 1'b0;
  endtask

  task automatic send_rand();
    logic [22:0] ph;
    if ($urandom_range(0, 1) == 1)
      ph = 23'($urandom_range(0, 2 * PI) - PI);
    else
      ph = 23'($urandom);
    send(ph, model(ph));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge iClk);
      n++;
    end
    #1;
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  task automatic check_reset_state(string nm);
    @(negedge iClk);
    check(nm, 64'({bus.oValid, bus.oPhase_abs, bus.oSign, bus.oFold,
                   bus.oRange_err, bus.oReady}), 64'(1));
  endtask

  task automatic latency_check();
    @(negedge iClk);
    check("lat_s1_only", 64'(bus.oValid), 64'(0));
    @(negedge iClk);
    check("lat_out", 64'(bus.oValid), 64'(1));
    @(posedge iClk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iReset = 1'b1;
    bus.iValid = 1'b0;
    bus.iPhase = '0;
    bus.iReady = 1'b1;
    repeat (2) @(posedge iClk);
    #1;
    iReset = 1'b0;
    check_reset_state("reset_state");
    @(posedge iClk);
    #1;

    send(23'h0C90FE, mk(32'h0C90FE, 0, 0, 0));
    latency_check();

    send(23'(2470649), mk(823550, 1, 1, 0));
    send(23'(-2470649), mk(823550, 0, 1, 0));
    send(23'(HP), mk(HP, 0, 0, 0));
    send(23'(-HP), mk(HP, 1, 0, 0));
    send(23'(HP + 1), mk(HP, 1, 1, 0));
    send(23'(-HP - 1), mk(HP, 0, 1, 0));
    send(23'(PI), mk(0, 0, 1, 0));
    send(23'(-PI), mk(0, 0, 1, 0));
    send(23'(PI + 1), mk(0, 0, 1, 1));
    send(23'(4000000), mk(0, 0, 1, 1));
    send(23'(-4000000), mk(0, 0, 1, 1));
    send(23'(0), mk(0, 0, 0, 0));
    send(23'(-1), mk(1, 1, 0, 0));
    drain();

    saw_not_ready = 1'b0;
    stall_cyc = 0;
    bp_mode = 2;
    repeat (8) send_rand();
    drain();
    check("ready_dropped", 64'(saw_not_ready), 64'(1));
    bp_mode = 0;
    @(posedge iClk);
    #1;

    send(23'(100), mk(100, 0, 0, 0));
    send(23'(-200), mk(200, 1, 0, 0));
    iReset = 1'b1;
    @(posedge iClk);
    #1;
    iReset = 1'b0;
    check_reset_state("midstream_reset");
    repeat (3) begin
      @(negedge iClk);
      check("no_stale", 64'(bus.oValid), 64'(0));
    end
    @(posedge iClk);
    #1;
    send(23'(2470649), mk(823550, 1, 1, 0));
    latency_check();
    drain();

    bp_mode = 1;
    repeat (300) begin
      send_rand();
      if ($urandom_range(0, 4) == 0) begin
        @(posedge iClk);
        #1;
      end
    end
    drain();
    bp_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
